// File: rtl/conv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_pkg
//  Description : Shared constants and types for the punctured K=7
//                convolutional encoder: generator polynomials, rate
//                encodings, per-rate/per-phase puncture keep masks and the
//                pending coded-bit buffer layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_enc_pkg;

    // Generator polynomials, MSB applies to the incoming bit, LSB to the
    // oldest stored bit.
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    // Rate encodings as seen on rate_sel (3 folds onto 1/2).
    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_3_4 = 2'd2;

    localparam int NUM_RATES  = 3;
    localparam int NUM_PHASES = 3;

    // Keep masks {keep_a, keep_b} indexed [rate][phase]. Phases a rate never
    // reaches are filled with "keep both" so no entry is ever empty.
    localparam logic [1:0] KEEP_MASK [NUM_RATES][NUM_PHASES] = '{
        '{2'b11, 2'b11, 2'b11},   // 1/2
        '{2'b11, 2'b10, 2'b11},   // 2/3
        '{2'b11, 2'b10, 2'b01}    // 3/4
    };

    // Highest phase value before wrapping back to 0, per rate.
    localparam logic [1:0] PHASE_LAST [NUM_RATES] = '{2'd0, 2'd1, 2'd2};

    // Pending output buffer: bits[0] is the head, count is 0..2.
    typedef struct packed {
        logic [1:0] bits;
        logic [1:0] count;
        logic       last;
    } pend_buf_t;

    // The reserved encoding behaves as rate 1/2.
    function automatic logic [1:0] norm_rate(input logic [1:0] sel);
        return (sel == 2'd3) ? RATE_1_2 : sel;
    endfunction

    // Number of coded bits a keep mask produces (1 or 2).
    function automatic logic [1:0] kept_count(input logic [1:0] mask);
        return {1'b0, mask[1]} + {1'b0, mask[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_core
//  Description : 6-bit encoder shift register and the two parity outputs
//                (A from G0, B from G1) for the current input bit.
//  Ports       : clock, reset     - clock / synchronous active-high reset
//                i_advance        - shift i_data_bit into the register
//                i_clear          - zero the register (wins over i_advance)
//                i_data_bit       - bit currently offered
//                o_parity_a/b     - coded bits for i_data_bit
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_enc_core
    import conv_enc_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_advance,
    input  logic i_clear,
    input  logic i_data_bit,
    output logic o_parity_a,
    output logic o_parity_b
);

    // r_state[0] is the most recent previously accepted bit.
    logic [5:0] r_state;
    logic [6:0] w_taps;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_state <= '0;
        end else if (i_advance) begin
            r_state <= {r_state[4:0], i_data_bit};
        end
    end

    // Arrange the window newest-first so it lines up with the octal
    // generator bit order.
    assign w_taps = {i_data_bit, r_state[0], r_state[1], r_state[2],
                     r_state[3], r_state[4], r_state[5]};

    assign o_parity_a = ^(w_taps & G0);
    assign o_parity_b = ^(w_taps & G1);

endmodule
`default_nettype wire

// File: rtl/punctured_conv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : punctured_conv_encoder
//  Description : 802.11a/g K=7 (133/171) convolutional encoder with
//                on-the-fly puncturing to rates 1/2, 2/3 and 3/4. One data
//                bit in per handshake, serial coded bits out, valid/ready on
//                both sides.
//  Ports       : clock, reset          - clock / synchronous active-high reset
//                rate_sel[1:0]         - 0=1/2 1=2/3 2=3/4 3=1/2, taken at
//                                        the first bit of each packet
//                in_valid/in_ready     - input handshake
//                in_bit, in_last       - data bit, final bit of packet
//                out_valid/out_ready   - output handshake
//                out_bit, out_last     - coded bit, final coded bit
//  Revision    : 1.0 - initial release
// ============================================================================
module punctured_conv_encoder
    import conv_enc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rate_sel,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    logic [1:0] r_rate_q;
    logic [1:0] r_phase;
    logic       r_pkt_active;
    pend_buf_t  r_buf;

    logic       w_accept;
    logic       w_pop;
    logic       w_parity_a;
    logic       w_parity_b;
    logic [1:0] w_rate;
    logic [1:0] w_keep;
    logic [1:0] w_phase_next;
    pend_buf_t  w_buf_next;

    // ------------------------------------------------------------------
    // Handshakes. in_ready looks at out_ready combinationally so a
    // single-bit buffer can be drained and refilled in the same cycle,
    // which is what sustains a continuous out_valid.
    // ------------------------------------------------------------------
    assign in_ready  = !reset && ((r_buf.count == 2'd0) ||
                                  ((r_buf.count == 2'd1) && out_ready));
    assign out_valid = (r_buf.count != 2'd0);
    assign out_bit   = r_buf.bits[0];
    assign out_last  = out_valid && r_buf.last && (r_buf.count == 2'd1);

    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // The first bit of a packet uses rate_sel directly; later bits use the
    // latched copy so mid-packet changes have no effect.
    assign w_rate = r_pkt_active ? r_rate_q : norm_rate(rate_sel);
    assign w_keep = KEEP_MASK[w_rate][r_phase];

    conv_enc_core u_core (
        .clock      (clock),
        .reset      (reset),
        .i_advance  (w_accept),
        .i_clear    (w_accept && in_last),
        .i_data_bit (in_bit),
        .o_parity_a (w_parity_a),
        .o_parity_b (w_parity_b)
    );

    // ------------------------------------------------------------------
    // Puncture phase: wraps at the rate's period, restarts each packet.
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_next = r_phase + 2'd1;
        if (in_last || (r_phase >= PHASE_LAST[w_rate])) begin
            w_phase_next = 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Pending buffer. A load only happens when the buffer is empty or its
    // single remaining bit is leaving this cycle, so a load fully replaces
    // the contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_buf_next = r_buf;
        if (w_accept) begin
            w_buf_next.count = kept_count(w_keep);
            w_buf_next.last  = in_last;
            case (w_keep)
                2'b11:   w_buf_next.bits = {w_parity_b, w_parity_a};
                2'b10:   w_buf_next.bits = {1'b0, w_parity_a};
                default: w_buf_next.bits = {1'b0, w_parity_b};
            endcase
        end else if (w_pop) begin
            w_buf_next.bits  = {1'b0, r_buf.bits[1]};
            w_buf_next.count = r_buf.count - 2'd1;
            if (r_buf.count == 2'd1) begin
                w_buf_next.last = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rate_q     <= RATE_1_2;
            r_phase      <= 2'd0;
            r_pkt_active <= 1'b0;
            r_buf        <= '0;
        end else begin
            r_buf <= w_buf_next;
            if (!r_pkt_active) begin
                r_rate_q <= norm_rate(rate_sel);
            end
            if (w_accept) begin
                r_phase      <= w_phase_next;
                r_pkt_active <= !in_last;
            end
        end
    end

endmodule
`default_nettype wire
